// File: rtl/mul_sched_pkg.sv
// Shared types and the round-robin search used by the multiply request scheduler.
package mul_sched_pkg;

  // Ids are sized for the largest supported requester count (8).
  localparam int unsigned REQ_MAX  = 8;
  localparam int unsigned ID_MAX_W = $clog2(REQ_MAX);

  typedef logic [ID_MAX_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  typedef struct packed {
    logic    found;
    req_id_t id;
  } grant_t;

  // First eligible requester after ptr, wrapping modulo num_req.
  function automatic grant_t rr_next(input req_id_t ptr,
                                     input logic [REQ_MAX-1:0] eligible,
                                     input int unsigned num_req);
    grant_t      g;
    int unsigned idx;
    g = '0;
    for (int unsigned k = 1; k <= REQ_MAX; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= num_req) idx = idx - num_req;
      if (!g.found && (k <= num_req) && eligible[3'(idx)]) begin
        g.found = 1'b1;
        g.id    = req_id_t'(idx);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mul_tag_pipe.sv
// Owner-tag delay line that tracks each product through the multiplier pipeline.
module mul_tag_pipe
  import mul_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], tag_in};
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mul_req_scheduler.sv
// Round-robin front end sharing one multiply array between several requesters,
// returning each fixed-latency product to the requester that issued it.
module mul_req_scheduler
  import mul_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned NUM_ELEMENTS    = 33,
  parameter int unsigned A_BIT_LEN       = 17,
  parameter int unsigned B_BIT_LEN       = 17,
  parameter int unsigned MUL_LATENCY     = 3,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [NUM_REQ-1:0]                                   req_valid,
  output logic [NUM_REQ-1:0]                                   req_ready,
  input  logic [NUM_REQ-1:0][NUM_ELEMENTS-1:0][A_BIT_LEN-1:0]  req_a,
  input  logic [NUM_REQ-1:0][NUM_ELEMENTS-1:0][B_BIT_LEN-1:0]  req_b,
  output logic [NUM_ELEMENTS-1:0][A_BIT_LEN-1:0]               mul_a,
  output logic [NUM_ELEMENTS-1:0][B_BIT_LEN-1:0]               mul_b,
  input  logic [2*NUM_ELEMENTS-1:0][B_BIT_LEN-1:0]             mul_out,
  output logic [NUM_REQ-1:0]                                   rsp_valid,
  output logic [2*NUM_ELEMENTS-1:0][B_BIT_LEN-1:0]             rsp_data,
  output logic [ID_W-1:0]                                      rsp_id,
  output logic                                                 idle
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DEPTH = MUL_LATENCY + 1;

  req_id_t                                   rr_ptr;
  logic [NUM_REQ-1:0][CNT_W-1:0]             outstanding;
  logic [NUM_REQ-1:0]                        eligible;
  logic [NUM_REQ-1:0]                        retire;
  grant_t                                    grant;
  logic                                      accept;
  tag_t                                      tag_in;
  tag_t                                      tag_out;
  logic [NUM_ELEMENTS-1:0][A_BIT_LEN-1:0]    sel_a;
  logic [NUM_ELEMENTS-1:0][B_BIT_LEN-1:0]    sel_b;

  // One-hot decode of the tag leaving the delay line.
  always_comb begin
    retire = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      retire[i] = tag_out.valid && (tag_out.id == req_id_t'(i));
    end
  end

  // A result retiring this cycle frees its slot for an accept in the same cycle.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] &&
                    ((32'(outstanding[i]) - 32'(retire[i])) < MAX_OUTSTANDING);
    end
  end

  // Grant and operand select.
  always_comb begin
    grant     = rr_next(rr_ptr, REQ_MAX'(eligible), NUM_REQ);
    accept    = grant.found && !reset;
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant.id == req_id_t'(i));
      if (req_ready[i]) begin
        sel_a = req_a[i];
        sel_b = req_b[i];
      end
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept;
    if (accept) tag_in.id = grant.id;
  end

  // Operand registers hold their value between accepts to avoid array toggling.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= req_id_t'(NUM_REQ - 1);
      mul_a  <= '0;
      mul_b  <= '0;
    end else if (accept) begin
      rr_ptr <= grant.id;
      mul_a  <= sel_a;
      mul_b  <= sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        case ({req_ready[i], retire[i]})
          2'b10:   outstanding[i] <= outstanding[i] + CNT_W'(1);
          2'b01:   outstanding[i] <= outstanding[i] - CNT_W'(1);
          default: outstanding[i] <= outstanding[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        assert (!(retire[i] && !req_ready[i] && (outstanding[i] == '0)));
        assert (!(req_ready[i] && !retire[i] && (32'(outstanding[i]) >= MAX_OUTSTANDING)));
      end
    end
  end

  mul_tag_pipe #(
    .DEPTH (DEPTH)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_comb begin
    rsp_valid = retire;
    rsp_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (retire[i]) rsp_id = ID_W'(i);
    end
    rsp_data  = mul_out;
    idle      = (outstanding == '0) && !accept;
  end

endmodule

// File: tb/tb_mul_req_scheduler.sv
// Directed and random stimulus for mul_req_scheduler against a queue-based model of in-flight operations.
module tb_mul_req_scheduler;

  localparam int unsigned NR   = 2;
  localparam int unsigned NE   = 33;
  localparam int unsigned AW   = 17;
  localparam int unsigned BW   = 17;
  localparam int unsigned LAT  = 3;
  localparam int unsigned MAXO = 2;
  localparam int unsigned IDW  = 1;

  typedef logic [NE-1:0][AW-1:0]   opa_t;
  typedef logic [NE-1:0][BW-1:0]   opb_t;
  typedef logic [2*NE-1:0][BW-1:0] prod_t;
  typedef struct {
    int   id;
    int   due;
    opa_t a;
    opb_t b;
  } op_t;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NR-1:0]               req_valid;
  logic [NR-1:0]               req_ready;
  logic [NR-1:0][NE-1:0][AW-1:0] req_a;
  logic [NR-1:0][NE-1:0][BW-1:0] req_b;
  opa_t                        mul_a;
  opb_t                        mul_b;
  prod_t                       mul_out;
  logic [NR-1:0]               rsp_valid;
  prod_t                       rsp_data;
  logic [IDW-1:0]              rsp_id;
  logic                        idle;

  mul_req_scheduler #(
    .NUM_REQ         (NR),
    .NUM_ELEMENTS    (NE),
    .A_BIT_LEN       (AW),
    .B_BIT_LEN       (BW),
    .MUL_LATENCY     (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // Stand-in multiply array: word-wise convolution, truncated per word.
  function automatic prod_t mul_f(input opa_t a, input opb_t b);
    logic [63:0] acc [2*NE];
    prod_t       p;
    for (int j = 0; j < 2*NE; j++) acc[j] = '0;
    for (int i = 0; i < NE; i++)
      for (int k = 0; k < NE; k++)
        acc[i+k] = acc[i+k] + 64'(a[i]) * 64'(b[k]);
    for (int j = 0; j < 2*NE; j++) p[j] = acc[j][BW-1:0];
    return p;
  endfunction

  prod_t mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_f(mul_a, mul_b);
    for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_out = mpipe[LAT-1];

  op_t   q[$];
  int    last_id;
  int    cyc;
  int    n_chk;
  int    n_pass;
  opa_t  exp_ma;
  opb_t  exp_mb;
  prod_t last_rsp;

  task automatic check(input string tag, input logic [1199:0] obs, input logic [1199:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic rand_ops();
    for (int r = 0; r < NR; r++)
      for (int w = 0; w < NE; w++) begin
        req_a[r][w] = AW'($urandom);
        req_b[r][w] = BW'($urandom);
      end
  endtask

  task automatic ones_ops();
    for (int r = 0; r < NR; r++)
      for (int w = 0; w < NE; w++) begin
        req_a[r][w] = AW'(1);
        req_b[r][w] = BW'(1);
      end
  endtask

  // Check one cycle against the model, then advance to the next negedge.
  task automatic step();
    int            ret;
    int            cnt [NR];
    logic [NR-1:0] elig;
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] exp_rv;
    int            gid;
    logic          found;
    int            exp_id;
    int            bad;
    prod_t         exp_data;
    #1;
    if (reset) begin
      check("ready_in_reset", 1200'(req_ready), 1200'(0));
      @(posedge clk);
      q.delete();
      last_id = NR - 1;
      exp_ma  = '0;
      exp_mb  = '0;
      cyc++;
      @(negedge clk);
      return;
    end
    ret = -1;
    foreach (q[n]) if (q[n].due == cyc) ret = n;
    for (int r = 0; r < NR; r++) cnt[r] = 0;
    foreach (q[n]) if (q[n].due != cyc) cnt[q[n].id]++;
    for (int r = 0; r < NR; r++) elig[r] = req_valid[r] && (cnt[r] < int'(MAXO));
    found = 1'b0;
    gid   = 0;
    for (int k = 1; k <= int'(NR); k++) begin
      int r;
      r = (last_id + k) % int'(NR);
      if (!found && elig[r]) begin
        found = 1'b1;
        gid   = r;
      end
    end
    exp_ready = '0;
    if (found) exp_ready[gid] = 1'b1;
    exp_rv = '0;
    exp_id = 0;
    if (ret >= 0) begin
      exp_rv[q[ret].id] = 1'b1;
      exp_id = q[ret].id;
    end
    check("req_ready", 1200'(req_ready), 1200'(exp_ready));
    check("idle", 1200'(idle), 1200'((q.size() == 0) && !found));
    check("rsp_valid", 1200'(rsp_valid), 1200'(exp_rv));
    check("rsp_id", 1200'(rsp_id), 1200'(exp_id));
    check("mul_a", 1200'(mul_a), 1200'(exp_ma));
    check("mul_b", 1200'(mul_b), 1200'(exp_mb));
    if (ret >= 0) begin
      exp_data = mul_f(q[ret].a, q[ret].b);
      last_rsp = rsp_data;
      n_chk++;
      assert (rsp_data === exp_data) n_pass++;
      else begin
        bad = 0;
        for (int w = 2*NE-1; w >= 0; w--) if (rsp_data[w] !== exp_data[w]) bad = w;
        $error("FAIL rsp_data: word %0d observed %0h expected %0h", bad, rsp_data[bad], exp_data[bad]);
      end
      q.delete(ret);
    end
    if (found) begin
      q.push_back('{gid, cyc + 1 + int'(LAT), req_a[gid], req_b[gid]});
      last_id = gid;
      exp_ma  = req_a[gid];
      exp_mb  = req_b[gid];
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    cyc      = 0;
    last_id  = NR - 1;
    exp_ma   = '0;
    exp_mb   = '0;
    last_rsp = '0;
    reset    = 1'b1;
    req_valid = '1;
    rand_ops();
    @(negedge clk);
    step();
    step();
    reset     = 1'b0;
    req_valid = '0;
    step();

    // single all-ones operation, then a long quiet stretch
    ones_ops();
    req_valid = 2'b01;
    step();
    req_valid = '0;
    rand_ops();
    repeat (10) step();
    check("ones_word0", 1200'(last_rsp[0]), 1200'(17'd1));
    check("ones_word32", 1200'(last_rsp[32]), 1200'(17'd33));
    check("ones_word64", 1200'(last_rsp[64]), 1200'(17'd1));

    // both requesters contending
    req_valid = 2'b11;
    repeat (8) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (6) step();

    // requester 0 alone hits its in-flight limit
    req_valid = 2'b01;
    repeat (10) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (6) step();

    // requester 0 saturated while requester 1 fills the slots
    req_valid = 2'b01;
    repeat (2) begin rand_ops(); step(); end
    req_valid = 2'b11;
    repeat (8) begin rand_ops(); step(); end
    req_valid = '0;
    repeat (6) step();

    // reset with operations in flight
    req_valid = 2'b11;
    repeat (3) begin rand_ops(); step(); end
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = '0;
    repeat (8) step();
    req_valid = 2'b11;
    rand_ops();
    step();
    req_valid = '0;
    repeat (6) step();

    // random traffic with occasional resets
    repeat (300) begin
      req_valid = NR'($urandom);
      reset     = ($urandom_range(0, 49) == 0);
      rand_ops();
      step();
    end
    reset     = 1'b0;
    req_valid = '0;
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
